sc_bitstream_accumulator: RTL and testbench

Downstream stage of the LFSR stochastic bitstream generator. Counts the ones in a fixed-length window of the stochastic bitstream and emits the binary estimate of k.
Sits between the generator's bitstream output and the decompressor's result path. It also drives the generator's enable while a window is open.
Hands one result per window to the consumer over a valid/ready handshake.

---
 rtl/sc_pkg.sv | 23 ++
 rtl/sc_window_counter.sv | 47 ++++
 rtl/sc_bitstream_accumulator.sv | 111 +++++++++++
 tb/tb_sc_bitstream_accumulator.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic bitstream accumulator.
package sc_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StHold  = 2'd2
    } state_e;

    localparam int unsigned DefaultN      = 8;
    localparam int unsigned DefaultWindow = 2 ** DefaultN;

    // Ceiling log2; used to check that CW can represent WINDOW inclusive.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((64'd1 << r) < 64'(value))) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Sample/ones counter pair for one conversion window; done flags the sample that closes it.
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int unsigned CW     = 9,
    parameter int unsigned WINDOW = DefaultWindow
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          inc_en_i,
    input  logic          bit_i,
    output logic [CW-1:0] sample_cnt_o,
    output logic [CW-1:0] ones_cnt_o,
    output logic          done_o
);

    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic [CW-1:0] ones_cnt_q, ones_cnt_d;

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        if (clear_i) begin
            sample_cnt_d = '0;
            ones_cnt_d   = '0;
        end else if (inc_en_i) begin
            sample_cnt_d = sample_cnt_q + CW'(1);
            ones_cnt_d   = ones_cnt_q + CW'(bit_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sample_cnt_q <= '0;
            ones_cnt_q   <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
        end
    end

    assign done_o       = inc_en_i && ((sample_cnt_q + CW'(1)) == CW'(WINDOW));
    assign sample_cnt_o = sample_cnt_q;
    assign ones_cnt_o   = ones_cnt_q;

endmodule

// File: rtl/sc_bitstream_accumulator.sv
// Counts ones over a WINDOW-sample stochastic bitstream and hands the count out via valid/ready.
// Optional abort input enabled by defining SC_ABORT_EN.
module sc_bitstream_accumulator
    import sc_pkg::*;
#(
    parameter int unsigned N      = DefaultN,
    parameter int unsigned WINDOW = 2 ** N,
    parameter int unsigned CW     = N + 1
) (
    input  logic          clk,
    input  logic          rst,
`ifdef SC_ABORT_EN
    input  logic          abort,
`endif
    input  logic          start,
    input  logic          bit_in,
    input  logic          bit_valid,
    output logic          gen_enable,
    output logic          busy,
    output logic [CW-1:0] result,
    output logic          result_valid,
    input  logic          result_ready
);

    if ((WINDOW < 1) || (WINDOW > 2 ** N)) begin : g_bad_window
        $error("WINDOW must lie in 1..2**N");
    end
    if (clog2(WINDOW + 1) > CW) begin : g_bad_cw
        $error("CW too narrow to hold WINDOW");
    end

    state_e        state_q;
    logic [CW-1:0] result_q;
    logic          result_valid_q;

    logic          abort_act;
    logic          cnt_clear;
    logic          cnt_inc;
    logic          win_done;
    logic [CW-1:0] sample_cnt;
    logic [CW-1:0] ones_cnt;

`ifdef SC_ABORT_EN
    assign abort_act = abort && (state_q == StAccum);
`else
    assign abort_act = 1'b0;
`endif

    // Counters sit at zero throughout IDLE so a window always opens from a clean count.
    assign cnt_clear = (state_q == StIdle) || abort_act;
    assign cnt_inc   = (state_q == StAccum) && bit_valid && !abort_act;

    sc_window_counter #(
        .CW     (CW),
        .WINDOW (WINDOW)
    ) u_window_counter (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (cnt_clear),
        .inc_en_i     (cnt_inc),
        .bit_i        (bit_in),
        .sample_cnt_o (sample_cnt),
        .ones_cnt_o   (ones_cnt),
        .done_o       (win_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    if (abort_act) begin
                        state_q <= StIdle;
                    end else if (win_done) begin
                        result_q       <= ones_cnt + CW'(bit_in);
                        result_valid_q <= 1'b1;
                        state_q        <= StHold;
                    end
                end
                StHold: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The window must close before the sample count can reach WINDOW while accumulating.
    always_comb begin
        if (state_q == StAccum) begin
            assert (sample_cnt < CW'(WINDOW));
        end
    end

    assign gen_enable   = (state_q == StAccum);
    assign busy         = (state_q != StIdle);
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_sc_bitstream_accumulator.sv
// Randomised self-checking bench: WINDOW=8 main instance plus a WINDOW=1 boundary instance.
module tb_sc_bitstream_accumulator;

    localparam int unsigned N      = 3;
    localparam int unsigned WINDOW = 8;
    localparam int unsigned CW     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, bit_in, bit_valid, result_ready;
    logic          gen_enable, busy, result_valid;
    logic [CW-1:0] result;
`ifdef SC_ABORT_EN
    logic          abort;
`endif

    logic          start1, bit1, bit_valid1, ready1;
    logic          gen1, busy1, rv1;
    logic [CW-1:0] result1;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [CW-1:0] last_result;

    always #5 clk = ~clk;

    sc_bitstream_accumulator #(
        .N      (N),
        .WINDOW (WINDOW),
        .CW     (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef SC_ABORT_EN
        .abort        (abort),
`endif
        .start        (start),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .gen_enable   (gen_enable),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    sc_bitstream_accumulator #(
        .N      (N),
        .WINDOW (1),
        .CW     (CW)
    ) dut_w1 (
        .clk          (clk),
        .rst          (rst),
`ifdef SC_ABORT_EN
        .abort        (1'b0),
`endif
        .start        (start1),
        .bit_in       (bit1),
        .bit_valid    (bit_valid1),
        .gen_enable   (gen1),
        .busy         (busy1),
        .result       (result1),
        .result_valid (rv1),
        .result_ready (ready1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full window: model the expected count from the valid samples only.
    task automatic do_window(input string name, input logic [7:0] bits, input int stall_at,
                             input int stall_len, input int rand_stalls, input int hold_cycles);
        logic [1:0] cyc[$];
        int         exp_ones;
        int         ns;
        exp_ones = 0;
        for (int i = 0; i < int'(WINDOW); i++) begin
            ns = (i == stall_at) ? stall_len : 0;
            if (rand_stalls != 0) ns += int'($urandom_range(0, 2));
            for (int s = 0; s < ns; s++) cyc.push_back({1'b0, 1'($urandom)});
            cyc.push_back({1'b1, bits[i]});
            exp_ones += int'(bits[i]);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if ({busy, gen_enable, result_valid} !== 3'b110 || result !== last_result) begin
            n_err++;
            $display("FAIL %s:open flags=%b result=%0d expected flags=110 result=%0d",
                     name, {busy, gen_enable, result_valid}, result, last_result);
        end
        for (int c = 0; c < cyc.size(); c++) begin
            bit_valid    = cyc[c][1];
            bit_in       = cyc[c][0];
            start        = 1'($urandom);
            result_ready = 1'($urandom);
            step();
            if (c < cyc.size() - 1) begin
                n_cmp++;
                if ({busy, gen_enable, result_valid} !== 3'b110 || result !== last_result) begin
                    n_err++;
                    $display("FAIL %s:accum c=%0d flags=%b result=%0d expected flags=110 result=%0d",
                             name, c, {busy, gen_enable, result_valid}, result, last_result);
                end
            end
        end
        bit_valid    = 1'b0;
        start        = 1'b0;
        result_ready = 1'b0;
        n_cmp++;
        if ({busy, gen_enable, result_valid} !== 3'b101 || result !== CW'(exp_ones)) begin
            n_err++;
            $display("FAIL %s:done flags=%b result=%0d expected flags=101 result=%0d",
                     name, {busy, gen_enable, result_valid}, result, exp_ones);
        end
        last_result = CW'(exp_ones);
        for (int h = 0; h < hold_cycles; h++) begin
            start = 1'($urandom) | (h == 0);
`ifdef SC_ABORT_EN
            abort = 1'b1;
`endif
            step();
            n_cmp++;
            if ({busy, gen_enable, result_valid} !== 3'b101 || result !== last_result) begin
                n_err++;
                $display("FAIL %s:hold h=%0d flags=%b result=%0d expected flags=101 result=%0d",
                         name, h, {busy, gen_enable, result_valid}, result, last_result);
            end
        end
        start = 1'b0;
`ifdef SC_ABORT_EN
        abort = 1'b0;
`endif
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        n_cmp++;
        if ({busy, gen_enable, result_valid} !== 3'b000 || result !== last_result) begin
            n_err++;
            $display("FAIL %s:handshake flags=%b result=%0d expected flags=000 result=%0d",
                     name, {busy, gen_enable, result_valid}, result, last_result);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_cmp++;
        if ({busy, gen_enable, result_valid} !== 3'b000 || result !== '0) begin
            n_err++;
            $display("FAIL reset flags=%b result=%0d expected flags=000 result=0",
                     {busy, gen_enable, result_valid}, result);
        end
        rst = 1'b0;
        last_result = '0;
        step();
    endtask

    task automatic test_ready_idle();
        result_ready = 1'b1;
        step();
        step();
        result_ready = 1'b0;
        n_cmp++;
        if ({busy, gen_enable, result_valid} !== 3'b000 || result !== last_result) begin
            n_err++;
            $display("FAIL ready_idle flags=%b result=%0d expected flags=000 result=%0d",
                     {busy, gen_enable, result_valid}, result, last_result);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            step();
        end
        bit_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, gen_enable, result_valid} !== 3'b000 || result !== '0) begin
            n_err++;
            $display("FAIL reset_mid flags=%b result=%0d expected flags=000 result=0",
                     {busy, gen_enable, result_valid}, result);
        end
        step();
        rst = 1'b0;
        last_result = '0;
        step();
        do_window("after_reset", 8'($urandom), -1, 0, 0, 0);
    endtask

    task automatic test_window1();
        logic [2:0] pat;
        pat = 3'b101;
        for (int k = 0; k < 3; k++) begin
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            bit_valid1 = 1'b0;
            bit1 = 1'b1;
            step();
            n_cmp++;
            if ({busy1, gen1, rv1} !== 3'b110) begin
                n_err++;
                $display("FAIL w1:stall k=%0d flags=%b expected 110", k, {busy1, gen1, rv1});
            end
            bit_valid1 = 1'b1;
            bit1 = pat[k];
            step();
            bit_valid1 = 1'b0;
            n_cmp++;
            if ({busy1, gen1, rv1} !== 3'b101 || result1 !== CW'(pat[k])) begin
                n_err++;
                $display("FAIL w1:done k=%0d flags=%b result=%0d expected flags=101 result=%0d",
                         k, {busy1, gen1, rv1}, result1, pat[k]);
            end
            ready1 = 1'b1;
            step();
            ready1 = 1'b0;
            n_cmp++;
            if ({busy1, gen1, rv1} !== 3'b000) begin
                n_err++;
                $display("FAIL w1:handshake k=%0d flags=%b expected 000", k, {busy1, gen1, rv1});
            end
        end
    endtask

`ifdef SC_ABORT_EN
    task automatic test_abort(input int at);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < at; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            step();
        end
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        abort     = 1'b1;
        step();
        abort     = 1'b0;
        bit_valid = 1'b0;
        n_cmp++;
        if ({busy, gen_enable, result_valid} !== 3'b000 || result !== last_result) begin
            n_err++;
            $display("FAIL abort at=%0d flags=%b result=%0d expected flags=000 result=%0d",
                     at, {busy, gen_enable, result_valid}, result, last_result);
        end
        do_window("after_abort", 8'($urandom), -1, 0, 0, 1);
    endtask
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; result_ready = 1'b0;
        start1 = 1'b0; bit1 = 1'b0; bit_valid1 = 1'b0; ready1 = 1'b0;
`ifdef SC_ABORT_EN
        abort = 1'b0;
`endif
        last_result = '0;
        test_reset();
        test_ready_idle();
        do_window("basic", 8'b0100_1101, -1, 0, 0, 0);
        do_window("stall", 8'b0100_1101, 4, 3, 0, 0);
        do_window("ones", 8'hFF, -1, 0, 0, 0);
        do_window("zeros", 8'h00, -1, 0, 0, 0);
        do_window("hold", 8'b1011_0111, -1, 0, 0, 5);
        do_window("back_to_back", 8'b1110_0001, -1, 0, 0, 0);
        test_reset_mid();
        for (int r = 0; r < 6; r++) begin
            do_window("random", 8'($urandom), -1, 0, 1, int'($urandom_range(0, 3)));
        end
        test_window1();
`ifdef SC_ABORT_EN
        test_abort(7);
        test_abort(3);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
